// File: rtl/hyper_todram_sched.sv
// Round-robin scheduler that splits four LSAB section transfers into
// page-safe chunks of at most 24 words for the shared DRAM block mover.
module hyper_todram_sched (
  input  logic         CLK,
  input  logic         RST,
  input  logic [3:0]   REQ_VALID,
  input  logic [127:0] REQ_ADDR,
  input  logic [47:0]  REQ_LEN,
  output logic [3:0]   REQ_ACCEPT,
  output logic [3:0]   DONE,
  output logic [3:0]   BUSY,
  input  logic [3:0]   LSAB_EMPTY,
  output logic [11:0]  BLCK_START,
  output logic [4:0]   BLCK_COUNT_REQ,
  output logic [1:0]   BLCK_SECTION,
  output logic         BLCK_ISSUE,
  input  logic [4:0]   BLCK_COUNT_SENT,
  input  logic         BLCK_WORKING,
  output logic [19:0]  MCU_PAGE_ADDR,
  output logic         MCU_REQUEST_ALIGN,
  input  logic         MCU_GRANT_ALIGN
);

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ISSUE, S_WAIT_START, S_WAIT_END, S_UPDATE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  pend_q, pend_d;
  logic [31:0] addr_q [4];
  logic [31:0] addr_d [4];
  logic [11:0] left_q [4];
  logic [11:0] left_d [4];
  logic [1:0]  last_q, last_d;
  logic [1:0]  sel_q, sel_d;
  logic [4:0]  sent_q, sent_d;
  logic [11:0] blck_start_q, blck_start_d;
  logic [4:0]  blck_count_req_q, blck_count_req_d;
  logic [1:0]  blck_section_q, blck_section_d;
  logic [19:0] mcu_page_addr_q, mcu_page_addr_d;
  logic        align_q, align_d;
  logic [3:0]  req_accept_q, req_accept_d;
  logic [3:0]  done_q, done_d;

  logic [3:0]  elig;
  logic        found;
  logic [1:0]  pick;
  logic [1:0]  idx;
  logic [12:0] page_room;
  logic [4:0]  chunk_len;
  logic [11:0] new_left;

  // Rotating priority search starting just after the last served section.
  always_comb begin
    elig  = pend_q & ~LSAB_EMPTY;
    found = 1'b0;
    pick  = 2'd0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Chunk length = min(24, words left, words to end of the 4096-word page).
  always_comb begin
    page_room = 13'h1000 - {1'b0, addr_q[pick][11:0]};
    chunk_len = 5'd24;
    if ({1'b0, left_q[pick]} < 13'd24) chunk_len = left_q[pick][4:0];
    if (page_room < {8'd0, chunk_len}) chunk_len = page_room[4:0];
  end

  always_comb begin
    state_d          = state_q;
    pend_d           = pend_q;
    addr_d           = addr_q;
    left_d           = left_q;
    last_d           = last_q;
    sel_d            = sel_q;
    sent_d           = sent_q;
    blck_start_d     = blck_start_q;
    blck_count_req_d = blck_count_req_q;
    blck_section_d   = blck_section_q;
    mcu_page_addr_d  = mcu_page_addr_q;
    align_d          = align_q;
    req_accept_d     = 4'd0;
    done_d           = 4'd0;
    new_left         = 12'd0;

    // Accept only touches idle sections; the chunk FSM only touches pending ones.
    for (int i = 0; i < 4; i++) begin
      if (REQ_VALID[i] && !pend_q[i]) begin
        addr_d[i]       = REQ_ADDR[32*i +: 32];
        left_d[i]       = REQ_LEN[12*i +: 12];
        req_accept_d[i] = 1'b1;
        if (REQ_LEN[12*i +: 12] == 12'd0) done_d[i] = 1'b1;
        else                              pend_d[i] = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          sel_d            = pick;
          blck_start_d     = addr_q[pick][11:0];
          blck_count_req_d = chunk_len;
          blck_section_d   = pick;
          mcu_page_addr_d  = addr_q[pick][31:12];
          align_d          = 1'b1;
          state_d          = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (MCU_GRANT_ALIGN && !BLCK_WORKING) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT_START;
      S_WAIT_START: begin
        if (BLCK_WORKING) state_d = S_WAIT_END;
      end
      S_WAIT_END: begin
        if (!BLCK_WORKING) begin
          sent_d  = BLCK_COUNT_SENT;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if ({7'd0, sent_q} >= left_q[sel_q]) new_left = 12'd0;
        else                                 new_left = left_q[sel_q] - {7'd0, sent_q};
        addr_d[sel_q] = addr_q[sel_q] + {27'd0, sent_q};
        left_d[sel_q] = new_left;
        if (new_left == 12'd0) begin
          pend_d[sel_q] = 1'b0;
          done_d[sel_q] = 1'b1;
        end
        align_d = 1'b0;
        last_d  = sel_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q          <= S_IDLE;
      pend_q           <= 4'd0;
      last_q           <= 2'd3;
      sel_q            <= 2'd0;
      sent_q           <= 5'd0;
      blck_start_q     <= 12'd0;
      blck_count_req_q <= 5'd0;
      blck_section_q   <= 2'd0;
      mcu_page_addr_q  <= 20'd0;
      align_q          <= 1'b0;
      req_accept_q     <= 4'd0;
      done_q           <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        addr_q[i] <= 32'd0;
        left_q[i] <= 12'd0;
      end
    end else begin
      state_q          <= state_d;
      pend_q           <= pend_d;
      last_q           <= last_d;
      sel_q            <= sel_d;
      sent_q           <= sent_d;
      blck_start_q     <= blck_start_d;
      blck_count_req_q <= blck_count_req_d;
      blck_section_q   <= blck_section_d;
      mcu_page_addr_q  <= mcu_page_addr_d;
      align_q          <= align_d;
      req_accept_q     <= req_accept_d;
      done_q           <= done_d;
      for (int i = 0; i < 4; i++) begin
        addr_q[i] <= addr_d[i];
        left_q[i] <= left_d[i];
      end
    end
  end

  assign REQ_ACCEPT        = req_accept_q;
  assign DONE              = done_q;
  assign BUSY              = pend_q;
  assign BLCK_START        = blck_start_q;
  assign BLCK_COUNT_REQ    = blck_count_req_q;
  assign BLCK_SECTION      = blck_section_q;
  assign BLCK_ISSUE        = (state_q == S_ISSUE);
  assign MCU_PAGE_ADDR     = mcu_page_addr_q;
  assign MCU_REQUEST_ALIGN = align_q;

endmodule

// File: tb/tb_hyper_todram_sched.sv
// Directed bench for hyper_todram_sched with a behavioural block mover
// and issue/DONE logs checked against hand-computed chunk sequences.
module tb_hyper_todram_sched;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [3:0]   REQ_VALID = 4'd0;
  logic [127:0] REQ_ADDR = '0;
  logic [47:0]  REQ_LEN = '0;
  logic [3:0]   REQ_ACCEPT, DONE, BUSY;
  logic [3:0]   LSAB_EMPTY = 4'd0;
  logic [11:0]  BLCK_START;
  logic [4:0]   BLCK_COUNT_REQ;
  logic [1:0]   BLCK_SECTION;
  logic         BLCK_ISSUE;
  logic [4:0]   BLCK_COUNT_SENT;
  logic         BLCK_WORKING;
  logic [19:0]  MCU_PAGE_ADDR;
  logic         MCU_REQUEST_ALIGN;
  logic         MCU_GRANT_ALIGN = 1'b1;

  hyper_todram_sched dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR),
    .REQ_LEN(REQ_LEN), .REQ_ACCEPT(REQ_ACCEPT), .DONE(DONE), .BUSY(BUSY),
    .LSAB_EMPTY(LSAB_EMPTY), .BLCK_START(BLCK_START),
    .BLCK_COUNT_REQ(BLCK_COUNT_REQ), .BLCK_SECTION(BLCK_SECTION),
    .BLCK_ISSUE(BLCK_ISSUE), .BLCK_COUNT_SENT(BLCK_COUNT_SENT),
    .BLCK_WORKING(BLCK_WORKING), .MCU_PAGE_ADDR(MCU_PAGE_ADDR),
    .MCU_REQUEST_ALIGN(MCU_REQUEST_ALIGN), .MCU_GRANT_ALIGN(MCU_GRANT_ALIGN)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  // Mover model: WORKING rises two edges after ISSUE, stays high COUNT_REQ
  // cycles; issue number short_at reports short_val words instead.
  int         short_at = -1;
  int         short_val = 5;
  int         issue_cnt;
  int         mv_phase;
  int         mv_cnt;
  logic [4:0] mv_req, mv_sent;

  always @(posedge CLK) begin
    if (!RST) begin
      BLCK_WORKING    <= 1'b0;
      BLCK_COUNT_SENT <= 5'd0;
      mv_phase        <= 0;
      issue_cnt       <= 0;
    end else begin
      case (mv_phase)
        0: if (BLCK_ISSUE) begin
          mv_req    <= BLCK_COUNT_REQ;
          mv_sent   <= (issue_cnt == short_at) ? 5'(short_val) : BLCK_COUNT_REQ;
          issue_cnt <= issue_cnt + 1;
          mv_phase  <= 1;
        end
        1: begin
          BLCK_WORKING <= 1'b1;
          mv_cnt       <= int'(mv_req);
          mv_phase     <= 2;
        end
        default: begin
          if (mv_cnt <= 1) begin
            BLCK_WORKING    <= 1'b0;
            BLCK_COUNT_SENT <= mv_sent;
            mv_phase        <= 0;
          end else begin
            mv_cnt <= mv_cnt - 1;
          end
        end
      endcase
    end
  end

  // Logs of every issued chunk and every DONE pulse
  logic [1:0]  sec_log[$];
  logic [11:0] start_log[$];
  logic [4:0]  cnt_log[$];
  logic [19:0] page_log[$];
  logic [1:0]  done_log[$];

  always @(negedge CLK) begin
    if (BLCK_ISSUE) begin
      sec_log.push_back(BLCK_SECTION);
      start_log.push_back(BLCK_START);
      cnt_log.push_back(BLCK_COUNT_REQ);
      page_log.push_back(MCU_PAGE_ADDR);
    end
    for (int i = 0; i < 4; i++)
      if (DONE[i]) done_log.push_back(2'(i));
  end

  // Scoreboard counters
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_chunk(input string tag, input int idx, input logic [1:0] sec,
                             input logic [11:0] start, input logic [4:0] cnt,
                             input logic [19:0] page);
    logic [31:0] s, st, c, p;
    s  = (idx < sec_log.size())   ? 32'(sec_log[idx])   : 32'hDEAD;
    st = (idx < start_log.size()) ? 32'(start_log[idx]) : 32'hDEAD;
    c  = (idx < cnt_log.size())   ? 32'(cnt_log[idx])   : 32'hDEAD;
    p  = (idx < page_log.size())  ? 32'(page_log[idx])  : 32'hDEAD;
    check({tag, "_sec"},   s,  32'(sec));
    check({tag, "_start"}, st, 32'(start));
    check({tag, "_cnt"},   c,  32'(cnt));
    check({tag, "_page"},  p,  32'(page));
  endtask

  function automatic logic [31:0] done_at(input int idx);
    return (idx < done_log.size()) ? 32'(done_log[idx]) : 32'hDEAD;
  endfunction

  // Driver tasks
  task automatic set_req(input int sec, input logic [31:0] addr, input logic [11:0] len);
    REQ_VALID[sec]       = 1'b1;
    REQ_ADDR[32*sec +: 32] = addr;
    REQ_LEN[12*sec +: 12]  = len;
  endtask

  task automatic do_reset();
    RST       = 1'b0;
    REQ_VALID = 4'd0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic wait_busy(input logic [3:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (BUSY !== target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(tag, 32'(BUSY), 32'(target));
  endtask

  int sb, db;

  initial begin
    @(negedge CLK);
    do_reset();

    // Reset state
    check("rst_busy",  32'(BUSY), 32'h0);
    check("rst_done",  32'(DONE), 32'h0);
    check("rst_acc",   32'(REQ_ACCEPT), 32'h0);
    check("rst_issue", 32'(BLCK_ISSUE), 32'h0);
    check("rst_start", 32'(BLCK_START), 32'h0);
    check("rst_cnt",   32'(BLCK_COUNT_REQ), 32'h0);
    check("rst_sec",   32'(BLCK_SECTION), 32'h0);
    check("rst_page",  32'(MCU_PAGE_ADDR), 32'h0);
    check("rst_align", 32'(MCU_REQUEST_ALIGN), 32'h0);

    // Single transfer: 50 words -> 24, 24, 2
    sb = sec_log.size(); db = done_log.size();
    set_req(0, 32'h0000_1000, 12'd50);
    @(negedge CLK);
    check("single_acc",  32'(REQ_ACCEPT), 32'h1);
    check("single_busy", 32'(BUSY), 32'h1);
    REQ_VALID = 4'd0;
    wait_busy(4'h0, 600, "single_idle");
    repeat (3) @(negedge CLK);
    check("single_nchunks", 32'(sec_log.size() - sb), 32'd3);
    check_chunk("single_c0", sb + 0, 2'd0, 12'h000, 5'd24, 20'h00001);
    check_chunk("single_c1", sb + 1, 2'd0, 12'h018, 5'd24, 20'h00001);
    check_chunk("single_c2", sb + 2, 2'd0, 12'h030, 5'd2,  20'h00001);
    check("single_ndone", 32'(done_log.size() - db), 32'd1);
    check("single_done0", done_at(db), 32'd0);

    // Page crossing: 0x2FF8 len 20 -> 8 on page 2, then 12 on page 3
    sb = sec_log.size(); db = done_log.size();
    set_req(2, 32'h0000_2FF8, 12'd20);
    @(negedge CLK);
    check("page_acc", 32'(REQ_ACCEPT), 32'h4);
    REQ_VALID = 4'd0;
    wait_busy(4'h0, 400, "page_idle");
    repeat (3) @(negedge CLK);
    check("page_nchunks", 32'(sec_log.size() - sb), 32'd2);
    check_chunk("page_c0", sb + 0, 2'd2, 12'hFF8, 5'd8,  20'h00002);
    check_chunk("page_c1", sb + 1, 2'd2, 12'h000, 5'd12, 20'h00003);
    check("page_done2", done_at(db), 32'd2);

    // Round-robin: four sections of 48 words each, from a fresh pointer
    do_reset();
    sb = sec_log.size(); db = done_log.size();
    for (int i = 0; i < 4; i++) set_req(i, 32'h0001_0000 * (i + 1), 12'd48);
    @(negedge CLK);
    check("rr_acc", 32'(REQ_ACCEPT), 32'hF);
    REQ_VALID = 4'd0;
    wait_busy(4'h0, 1500, "rr_idle");
    repeat (3) @(negedge CLK);
    check("rr_nchunks", 32'(sec_log.size() - sb), 32'd8);
    for (int k = 0; k < 8; k++)
      check_chunk($sformatf("rr_c%0d", k), sb + k, 2'(k % 4),
                  (k < 4) ? 12'h000 : 12'h018, 5'd24, 20'(16 * (k % 4 + 1)));
    for (int k = 0; k < 4; k++)
      check($sformatf("rr_done%0d", k), done_at(db + k), 32'(k));

    // Short send and empty skip: first chunk moves only 5 words, section 1 starved by LSAB_EMPTY
    do_reset();
    short_at   = 0;
    LSAB_EMPTY = 4'b0010;
    sb = sec_log.size(); db = done_log.size();
    set_req(0, 32'h0000_0000, 12'd24);
    set_req(1, 32'h0000_0100, 12'd24);
    set_req(2, 32'h0000_0200, 12'd24);
    @(negedge CLK);
    check("short_acc", 32'(REQ_ACCEPT), 32'h7);
    REQ_VALID = 4'd0;
    wait_busy(4'b0010, 600, "short_only_s1_left");
    repeat (3) @(negedge CLK);
    check("short_nchunks", 32'(sec_log.size() - sb), 32'd3);
    check_chunk("short_c0", sb + 0, 2'd0, 12'h000, 5'd24, 20'h0);
    check_chunk("short_c1", sb + 1, 2'd2, 12'h200, 5'd24, 20'h0);
    check_chunk("short_c2", sb + 2, 2'd0, 12'h005, 5'd19, 20'h0);
    check("short_ndone", 32'(done_log.size() - db), 32'd2);
    check("short_done_a", done_at(db), 32'd2);
    check("short_done_b", done_at(db + 1), 32'd0);
    short_at   = -1;
    LSAB_EMPTY = 4'd0;
    wait_busy(4'h0, 200, "short_s1_idle");
    repeat (3) @(negedge CLK);
    check_chunk("short_c3", sb + 3, 2'd1, 12'h100, 5'd24, 20'h0);
    check("short_done_c", done_at(db + 2), 32'd1);

    // Zero length: accept and DONE together, nothing issued
    sb = sec_log.size();
    set_req(3, 32'h0000_0500, 12'd0);
    @(negedge CLK);
    check("zero_acc",  32'(REQ_ACCEPT), 32'h8);
    check("zero_done", 32'(DONE), 32'h8);
    check("zero_busy", 32'(BUSY), 32'h0);
    REQ_VALID = 4'd0;
    repeat (20) @(negedge CLK);
    check("zero_noissue", 32'(sec_log.size() - sb), 32'd0);

    // Reset while the chunk is in WAIT_END
    sb = sec_log.size(); db = done_log.size();
    set_req(0, 32'h0000_0040, 12'd24);
    @(negedge CLK);
    REQ_VALID = 4'd0;
    for (int n = 0; n < 30 && BLCK_WORKING !== 1'b1; n++) @(negedge CLK);
    check("mid_working", 32'(BLCK_WORKING), 32'h1);
    @(negedge CLK);
    check("mid_align_before", 32'(MCU_REQUEST_ALIGN), 32'h1);
    RST = 1'b0;
    @(negedge CLK);
    check("mid_busy",  32'(BUSY), 32'h0);
    check("mid_align", 32'(MCU_REQUEST_ALIGN), 32'h0);
    check("mid_issue", 32'(BLCK_ISSUE), 32'h0);
    check("mid_cnt",   32'(BLCK_COUNT_REQ), 32'h0);
    check("mid_start", 32'(BLCK_START), 32'h0);
    check("mid_page",  32'(MCU_PAGE_ADDR), 32'h0);
    check("mid_done",  32'(DONE), 32'h0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (40) @(negedge CLK);
    check("mid_nodone",  32'(done_log.size() - db), 32'd0);
    check("mid_nchunks", 32'(sec_log.size() - sb), 32'd1);

    // Final report
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete, passed %0d of %0d", passes, checks);
    $fatal(1, "timeout");
  end

endmodule
